// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stage handshake bundle: upstream beat in, downstream beat out, flush.
// slave = the stage itself, master = the surrounding pipeline logic.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16
);
  logic              is_flush;
  logic              is_valid;
  logic              os_ready;
  logic [DATA_W-1:0] i_data;
  logic [CTRL_W-1:0] is_ctrl;
  logic              os_valid;
  logic              is_ready;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] os_ctrl;

  modport slave (
    input  is_flush, is_valid, i_data, is_ctrl, is_ready,
    output os_ready, os_valid, o_data, os_ctrl
  );

  modport master (
    output is_flush, is_valid, i_data, is_ctrl, is_ready,
    input  os_ready, os_valid, o_data, os_ctrl
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register: main + skid slot, valid/ready handshake, flush to zeroed bubble.
// Optional PIPE_STAGE_STATS_EN adds saturating delivered-beat and flushed-entry counters.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_buf_if.slave  bus
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] o_beat_count,
  output logic [CNT_W-1:0] o_drop_count
`endif
);

  localparam int unsigned PAY_W = DATA_W + CTRL_W;

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("pipe_stage_buf: CNT_W must be at least 1");
  end

  // State is the slot valid bits: {skid_valid, main_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e           state;
  state_e           state_nxt;
  logic             main_valid;
  logic             skid_valid;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] skid_q;
  logic [PAY_W-1:0] in_pay;
  logic             in_fire;
  logic             out_fire;
  logic             main_load_in;
  logic             main_load_skid;
  logic             main_clear;
  logic             skid_load;

  assign main_valid = state[0];
  assign skid_valid = state[1];
  assign in_pay     = {bus.is_ctrl, bus.i_data};

  // Ready never looks at downstream ready: the skid slot absorbs a late stall
  assign bus.os_ready = ~skid_valid & ~bus.is_flush;
  assign bus.os_valid = main_valid;
  assign bus.o_data   = main_q[DATA_W-1:0];
  assign bus.os_ctrl  = main_q[PAY_W-1:DATA_W];

  assign in_fire  = bus.is_valid & bus.os_ready;
  assign out_fire = main_valid & bus.is_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (bus.is_flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) state_nxt = ONE;
        end
        ONE: begin
          if (in_fire && !out_fire)      state_nxt = FULL;
          else if (!in_fire && out_fire) state_nxt = EMPTY;
        end
        FULL: begin
          if (out_fire) state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Slot update controls; any entry into EMPTY clears main so bubbles carry zero control
  always_comb begin
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    if (bus.is_flush) begin
      main_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          main_load_in = in_fire;
        end
        ONE: begin
          if (in_fire && out_fire) main_load_in = 1'b1;
          else if (in_fire)        skid_load    = 1'b1;
          else if (out_fire)       main_clear   = 1'b1;
        end
        FULL: begin
          main_load_skid = out_fire;
        end
        default: main_clear = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_clear)          main_q <= '0;
      else if (main_load_in)   main_q <= in_pay;
      else if (main_load_skid) main_q <= skid_q;
      if (skid_load)           skid_q <= in_pay;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]     drop_n;
  logic [CNT_W:0] drop_sum;

  // A main entry leaving in the flush cycle was delivered, not dropped
  always_comb begin
    drop_n = 2'd0;
    if (bus.is_flush) begin
      drop_n = 2'(main_valid & ~out_fire) + 2'(skid_valid);
    end
  end

  assign drop_sum = {1'b0, o_drop_count} + (CNT_W+1)'(drop_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_beat_count <= '0;
      o_drop_count <= '0;
    end else begin
      if (out_fire && (o_beat_count != CNT_MAX)) begin
        o_beat_count <= o_beat_count + CNT_W'(1);
      end
      if (drop_sum > {1'b0, CNT_MAX}) o_drop_count <= CNT_MAX;
      else                            o_drop_count <= drop_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It replaces the fixed, always-advancing inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Any stage can stall backwards without dropping a beat. A taken branch or jump flushes every in-flight entry to a zeroed bubble.

## Interface
Parameters:
- DATA_W, 32: width of the datapath payload (ALU result, rt value, PC+4, jump target, concatenated).
- CTRL_W, 16: width of the control payload (RegWrite, MemtoReg, MemWrite, MemRead, load/store type, register destination).
- CNT_W, 16: width of the statistics counters; only used with PIPE_STAGE_STATS_EN.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  stage clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- is_flush  in  1  discards all stored entries (taken jump/branch).
- is_valid  in  1  upstream beat present.
- os_ready  out  1  stage can accept a beat this cycle.
- i_data  in  DATA_W  upstream datapath payload.
- is_ctrl  in  CTRL_W  upstream control payload.
- os_valid  out  1  beat presented downstream.
- is_ready  in  1  downstream accepts the beat.
- o_data  out  DATA_W  downstream datapath payload.
- os_ctrl  out  CTRL_W  downstream control payload.
- o_beat_count  out  CNT_W  beats delivered downstream (macro only).
- o_drop_count  out  CNT_W  entries discarded by flush (macro only).

## Operation
- Storage: a main slot (drives the outputs) and a skid slot. Each slot holds one {data, ctrl} pair and a valid bit.
- in_fire = is_valid & os_ready.
- out_fire = os_valid & is_ready.
- os_ready = ~skid_valid & ~is_flush. It is combinational on is_flush only. It does not depend on is_ready.
- os_valid = main_valid, driven directly from a register.
- State machine, encoded by the slot valid bits:
  - EMPTY: on in_fire, load main, go to ONE.
  - ONE, in_fire & out_fire: main <= input, stay in ONE.
  - ONE, in_fire only: skid <= input, go to FULL.
  - ONE, out_fire only: go to EMPTY.
  - ONE, neither: hold.
  - FULL: os_ready = 0. On out_fire: main <= skid, go to ONE. Otherwise hold.
- Flush (is_flush = 1) overrides every transition:
  - Both slots go invalid next cycle, giving EMPTY.
  - No input beat is accepted, because os_ready = 0.
  - An out_fire in the flush cycle is a completed, legal transfer. Only the remaining entries are dropped.
- Bubble rule: whenever main is invalid, o_data and os_ctrl are all-zero. On any transition into EMPTY, main data/ctrl are written to 0. This guarantees zeroed control (no RegWrite or MemWrite) in bubbles, regardless of os_valid decoding downstream.
- Order: beats leave in arrival order. No beat is duplicated or lost except by flush.

## Timing
- Latency: a beat accepted at edge N is on the outputs after edge N (visible in cycle N+1). Minimum latency is one cycle.
- Throughput: one beat per cycle while is_ready = 1.
- The stage stays full-rate through a single-cycle stall, because the skid slot absorbs the beat.
- After a flush edge: os_valid = 0, o_data = 0, os_ctrl = 0, os_ready = 1 (unless is_flush is still asserted).
- Reset (rst = 1 at an edge) has priority over flush and over the handshake. Next cycle:
  - main_valid = 0 and skid_valid = 0.
  - o_data = 0, os_ctrl = 0, os_valid = 0.
  - os_ready = 1 once rst and is_flush are both low.
  - Counters = 0.
- Reset mid-stall: all held beats are lost. Reset is not counted as a drop.
- Inputs are sampled only when in_fire. i_data and is_ctrl are don't-care otherwise.

## Configuration
- Macro: PIPE_STAGE_STATS_EN.
- When defined:
  - o_beat_count and o_drop_count exist.
  - o_beat_count increments by 1 on each out_fire.
  - o_drop_count increments on each flush edge by the number of valid entries discarded (0, 1 or 2). An entry that transfers in the flush cycle is not counted as discarded.
  - Both counters saturate at 2^CNT_W−1 and clear only on rst.
- When undefined: both ports and the counter logic are absent. Handshake behaviour is identical.

## Test plan
- Reset with is_valid = 1 and i_data = 0xDEADBEEF → cycle after release: os_valid = 0, o_data = 0, os_ctrl = 0, os_ready = 1.
- Streaming: is_ready = 1, beats 1,2,3,4 on consecutive cycles → o_data = 1,2,3,4 on consecutive cycles, each one cycle after input, os_ready held at 1.
- Stall: beats 0xA, 0xB, 0xC with is_ready = 0 from the second cycle.
  - Expected: 0xA in main, 0xB in skid, os_ready = 0, 0xC held upstream.
  - Then raise is_ready: outputs 0xA, 0xB, 0xC in order, none lost.
- Flush while FULL (0x11 main, 0x22 skid) with is_ready = 0 → next cycle os_valid = 0, o_data = 0, os_ctrl = 0. With macro: o_drop_count = 2.
- Flush with is_ready = 1 and main = 0x33 → 0x33 counted as delivered (o_beat_count +1). Concurrent is_valid beat 0x44 is not accepted (os_ready = 0).
- Saturation (CNT_W = 4): 20 streamed beats → o_beat_count = 15.
